// File: rtl/seq_demux_deser.sv
// rtl/seq_demux_deser.sv - serial-to-parallel lane demultiplexer with sync framing and valid/ready output
module seq_demux_deser #(
    parameter int LANES = 4,
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [LANES-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] lane,
    output logic             locked,
    output logic             realign,
    output logic             overrun
);

    typedef enum logic {HUNT, FILL} state_t;

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] lane_n;
    logic [LANES-1:0] shadow, shadow_n;
    logic [LANES-1:0] word;
    logic [LANES-1:0] dout_n;
    logic             dout_valid_n, locked_n, realign_n, overrun_n;
    logic             accept, complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            lane       <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            realign    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            shadow     <= shadow_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            locked     <= locked_n;
            realign    <= realign_n;
            overrun    <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        lane_n       = lane;
        shadow_n     = shadow;
        dout_n       = dout;
        dout_valid_n = dout_valid;
        locked_n     = locked;
        realign_n    = 1'b0;
        overrun_n    = overrun;
        complete     = 1'b0;
        accept       = dout_valid & dout_ready;
        // Completed word is the shadow with the bit arriving this cycle merged in.
        word         = shadow;
        word[lane]   = din;

        if (accept) begin
            dout_valid_n = 1'b0;
        end

        case (state)
            HUNT: begin
                if (din_valid && sync) begin
                    shadow_n    = '0;
                    shadow_n[0] = din;
                    lane_n      = SEL_W'(1);
                    locked_n    = 1'b1;
                    state_n     = FILL;
                end
            end
            FILL: begin
                if (din_valid) begin
                    if (sync && (lane != '0)) begin
                        // Sync mid-word: drop the partial and restart at lane 0.
                        shadow_n    = '0;
                        shadow_n[0] = din;
                        lane_n      = SEL_W'(1);
                        realign_n   = 1'b1;
                    end else begin
                        shadow_n = word;
                        if (lane == LAST_LANE) begin
                            lane_n   = '0;
                            complete = 1'b1;
                        end else begin
                            lane_n = lane + SEL_W'(1);
                        end
                    end
                end
            end
            default: state_n = HUNT;
        endcase

        if (complete) begin
            if (!dout_valid || accept) begin
                dout_n       = word;
                dout_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_demux_deser.sv
// tb/tb_seq_demux_deser.sv - scoreboard testbench for seq_demux_deser
module tb_seq_demux_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [1:0] lane;
    logic       locked;
    logic       realign;
    logic       overrun;

    int         compared = 0;
    int         mismatched = 0;
    logic [3:0] sb_q[$];
    logic [3:0] exp_word;

    seq_demux_deser #(.LANES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .lane       (lane),
        .locked     (locked),
        .realign    (realign),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic d, input logic s);
        din       = d;
        sync      = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    // Pops the scoreboard head into exp_word; an empty queue counts as a mismatch.
    task automatic pop_expected(input string name);
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s: scoreboard empty, observed dout=%b", name, dout);
            exp_word = 4'bxxxx;
        end else begin
            exp_word = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        compared++;
        if ({dout, dout_valid, lane, locked, realign, overrun} !== 10'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got dout=%b v=%b lane=%0d lk=%b ra=%b ov=%b, want all 0",
                     dout, dout_valid, lane, locked, realign, overrun);
        end
        idle(1);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_word();
        dout_ready = 1'b1;
        sb_q.push_back(4'b1101);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        compared++;
        if (dout_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_valid: got %b want 1", dout_valid);
        end
        pop_expected("basic_dout");
        compared++;
        if (dout !== exp_word) begin
            mismatched++;
            $display("FAIL basic_dout: got %b want %b", dout, exp_word);
        end
        compared++;
        if ({locked, lane} !== 3'b1_00) begin
            mismatched++;
            $display("FAIL basic_lock_lane: got locked=%b lane=%0d want 1,0", locked, lane);
        end
        idle(1);
        compared++;
        if (dout_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_valid_drop: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_hunt_gaps();
        logic [3:0] bits;
        logic [1:0] exp_lane;
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b0);
            compared++;
            if ({lane, locked} !== 3'b00_0) begin
                mismatched++;
                $display("FAIL hunt_ignore%0d: got lane=%0d locked=%b want 0,0", i, lane, locked);
            end
        end
        bits = 4'b0110;
        sb_q.push_back(bits);
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i], i == 0);
            exp_lane = 2'(i + 1);
            idle(2);
            compared++;
            if (lane !== exp_lane) begin
                mismatched++;
                $display("FAIL gap_lane%0d: got %0d want %0d", i, lane, exp_lane);
            end
            if (i == 3) begin
                idle(0);
            end
        end
        // With ready high the word was already accepted; check it was presented.
        do_reset();
        dout_ready = 1'b0;
        sb_q.push_back(bits);
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i], i == 0);
            idle(3);
        end
        pop_expected("gap_dout");
        compared++;
        if (dout !== exp_word || dout_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL gap_dout: got %b v=%b want %b v=1", dout, dout_valid, exp_word);
        end
    endtask

    task automatic test_overrun();
        logic [3:0] a, b;
        do_reset();
        dout_ready = 1'b0;
        a = 4'b0011;
        b = 4'b1000;
        sb_q.push_back(a);
        for (int i = 0; i < 4; i++) send_bit(a[i], i == 0);
        for (int i = 0; i < 3; i++) send_bit(b[i], i == 0);
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_before: got %b want 0", overrun);
        end
        send_bit(b[3], 1'b0);
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL ovr_set: got %b want 1", overrun);
        end
        pop_expected("ovr_hold");
        compared++;
        if (dout !== exp_word || dout_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL ovr_hold: got %b v=%b want %b v=1", dout, dout_valid, exp_word);
        end
        dout_ready = 1'b1;
        idle(2);
        compared++;
        if (overrun !== 1'b1 || dout_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_sticky: got ov=%b v=%b want ov=1 v=0", overrun, dout_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        do_reset();
        dout_ready = 1'b0;
        a = 4'b1010;
        b = 4'b0101;
        sb_q.push_back(a);
        sb_q.push_back(b);
        for (int i = 0; i < 4; i++) send_bit(a[i], i == 0);
        for (int i = 0; i < 3; i++) send_bit(b[i], i == 0);
        pop_expected("b2b_first");
        compared++;
        if (dout !== exp_word || dout_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_first: got %b v=%b want %b v=1", dout, dout_valid, exp_word);
        end
        dout_ready = 1'b1;
        send_bit(b[3], 1'b0);
        dout_ready = 1'b0;
        pop_expected("b2b_second");
        compared++;
        if (dout !== exp_word || dout_valid !== 1'b1 || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_second: got %b v=%b ov=%b want %b v=1 ov=0",
                     dout, dout_valid, overrun, exp_word);
        end
        dout_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_realign();
        int pulses;
        logic [3:0] w;
        pulses = 0;
        dout_ready = 1'b0;
        w = 4'b1100;
        sb_q.push_back(w);
        send_bit(1'b1, 1'b1);
        pulses += int'(realign);
        send_bit(1'b1, 1'b0);
        pulses += int'(realign);
        send_bit(w[0], 1'b1);
        compared++;
        if (realign !== 1'b1 || lane !== 2'd1 || dout_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL realign_pulse: got ra=%b lane=%0d v=%b want 1,1,0", realign, lane, dout_valid);
        end
        pulses += int'(realign);
        for (int i = 1; i < 4; i++) begin
            send_bit(w[i], 1'b0);
            pulses += int'(realign);
        end
        compared++;
        if (pulses != 1) begin
            mismatched++;
            $display("FAIL realign_count: got %0d want 1", pulses);
        end
        pop_expected("realign_word");
        compared++;
        if (dout !== exp_word || dout_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL realign_word: got %b v=%b want %b v=1", dout, dout_valid, exp_word);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] w;
        // dout_valid is still held from the previous scenario.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({dout, dout_valid, lane, locked, realign, overrun} !== 10'b0) begin
            mismatched++;
            $display("FAIL async_reset: got dout=%b v=%b lane=%0d lk=%b ra=%b ov=%b, want all 0",
                     dout, dout_valid, lane, locked, realign, overrun);
        end
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        idle(1);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        compared++;
        if ({lane, locked, dout_valid} !== 4'b0) begin
            mismatched++;
            $display("FAIL post_reset_hunt: got lane=%0d lk=%b v=%b want 0,0,0", lane, locked, dout_valid);
        end
        w = 4'b1010;
        sb_q.push_back(w);
        for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
        pop_expected("post_reset_word");
        compared++;
        if (dout !== exp_word || dout_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL post_reset_word: got %b v=%b want %b v=1", dout, dout_valid, exp_word);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic_word();
        test_hunt_gaps();
        test_overrun();
        test_back_to_back();
        test_realign();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_demux_deser.md
# seq_demux_deser

Sequential 1-to-LANES demultiplexer: the receive end of a select-rotating mux serializer. It captures a framed serial bitstream one bit per valid cycle and steers each bit to a lane register chosen by a rotating select counter. Each completed word is presented on a parallel valid/ready output. The block sits between a discrete-logic serial link and the parallel consumer logic that the FET techmap flow synthesises.

## Interface
- `LANES`, default 4: number of output lanes (bits per word). Legal range is ≥ 2.
- `SEL_W`, default `$clog2(LANES)`: width of the lane select counter. Derived; do not override.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is valid this cycle.
- `sync`  in  1  frame marker; qualified by `din_valid`; marks the bit for lane 0.
- `dout`  out  LANES  completed word; `dout[i]` is the i-th bit after sync.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `lane`  out  SEL_W  lane index the next valid bit will be written to.
- `locked`  out  1  frame alignment acquired.
- `realign`  out  1  one-cycle pulse on a mid-word sync.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- Reset values: state HUNT; `lane`=0; shadow register 0; `dout`=0; `dout_valid`=0; `locked`=0; `realign`=0; `overrun`=0.
- HUNT state:
  - `din_valid` without `sync` is ignored.
  - `din_valid & sync`: write `din` to shadow[0], set `lane`=1 and `locked`=1, go to FILL.
- FILL state, on `din_valid` with `sync`=0:
  - Write shadow[`lane`] = `din`.
  - If `lane` < LANES-1, increment `lane`.
  - If `lane` = LANES-1, the word is complete and `lane` wraps to 0.
- FILL state, on `din_valid & sync` with `lane`=0: this is a normal word start and is handled as the plain FILL case above.
- FILL state, on `din_valid & sync` with `lane`≠0 (misalignment):
  - Discard the partial shadow contents.
  - Write `din` to lane 0 and set `lane`=1.
  - Pulse `realign` for one cycle. No word is emitted.
- `sync` without `din_valid` has no effect in any state.
- Word completion: the complete word is the shadow contents with the final bit merged in.
  - If `dout_valid`=0, or `dout_valid & dout_ready` in the same cycle: load `dout` and set `dout_valid`=1.
  - Otherwise (output still held): drop the word, leave `dout` unchanged, set `overrun`=1.
- Output handshake:
  - `dout_valid & dout_ready` with no completion in the same cycle clears `dout_valid`.
  - `dout` is stable while `dout_valid`=1 and not accepted.
- `overrun` clears only on reset. `locked` clears only on reset.
- Asynchronous reset mid-word discards the partial word and any held output, and returns to HUNT.

## Timing
- Latency: `dout_valid` rises on the clock edge that samples the last bit of a word. It is visible in the cycle after the final `din_valid`.
- Accept-and-complete in the same cycle: `dout_valid` stays 1 with no bubble, and `dout` takes the new word on that edge.
- `lane`, `locked`, `realign` and `overrun` are registered. Each updates on the edge that samples the triggering `din_valid` cycle.
- Gaps in `din_valid` stall the counter. Word contents do not depend on gap length.
- Throughput is 1 bit/cycle, i.e. one word per LANES valid cycles, with no dead cycles at the wrap.

## Test plan
1. **Basic word:** LANES=4. Release reset, then drive four consecutive valid bits 1,0,1,1 with `sync` on the first and `dout_ready`=1.
   - Next cycle: `dout`=4'b1101, `dout_valid`=1 for one cycle.
   - `locked`=1, `lane`=0.
2. **Hunt and gaps:** drive three valid bits without `sync` (ignored, `lane` stays 0). Then send `sync`+bits 0,1,1,0 with idle cycles between each.
   - `dout`=4'b0110.
   - `lane` steps 1,2,3,0 only on valid cycles.
3. **Backpressure overrun:** `dout_ready`=0. Send word A=4'b0011, then word B=4'b1000.
   - `dout` stays 4'b0011, `dout_valid`=1.
   - `overrun` goes to 1 on B's last bit and stays 1 after `dout_ready` is raised.
4. **Back-to-back accept:** hold word A=4'b1010 with `dout_valid`=1. Assert `dout_ready` on exactly the cycle word B=4'b0101 completes.
   - `dout`=4'b0101, `dout_valid` stays 1, `overrun` stays 0.
5. **Mid-word realign:** send `sync`+1,1 then `sync`+0,0,1,1.
   - `realign` pulses once at the second sync.
   - Next word is `dout`=4'b1100; the partial is never output.
6. **Async reset mid-word:** after 2 bits of a word (with a held `dout_valid`), pulse `rst_n` low between clock edges.
   - All outputs read 0 immediately.
   - Following valid bits without `sync` are ignored until the next `sync`.
